ip_hdr_prepend_tx: RTL
======================

// Module: ip_hdr_prepend_tx
// PURPOSE
//  Downstream of the IP encap TX controller. Accepts one 20-byte IPv4 header per packet on the meta channel.
//  Prepends that header to the following payload stream, re-aligning payload bytes across DATA_W-wide beats.
//  Emits a single contiguous header+payload stream to the Ethernet encap stage.
//  Byte 0 of every bus is the MSB byte; payload always has >=1 beat.
// PARAMETERS
//  DATA_W      256  data bus width in bits; multiple of 8; DATA_W/8 > 20 (IP_HDR_BYTES).
//  PADBYTES_W  $clog2(DATA_W/8)  width of padbytes fields (count of invalid trailing bytes on a last beat).
// PORTS
//  clk                 in   1           sole clock
//  rst_n               in   1           asynchronous, active-low reset
//  src_hdr_meta_val    in   1           header valid
//  src_hdr_meta_hdr    in   160         IPv4 header, byte 0 at [159:152]
//  hdr_src_meta_rdy    out  1           header accepted
//  src_hdr_data_val    in   1           payload beat valid
//  src_hdr_data        in   DATA_W      payload beat
//  src_hdr_data_last   in   1           final payload beat
//  src_hdr_data_padbytes in PADBYTES_W  invalid trailing bytes, meaningful only with last
//  hdr_src_data_rdy    out  1           payload beat accepted
//  hdr_dst_data_val    out  1           output beat valid
//  hdr_dst_data        out  DATA_W      output beat
//  hdr_dst_data_last   out  1           final output beat
//  hdr_dst_data_padbytes out PADBYTES_W invalid trailing bytes on last output beat, else 0
//  dst_hdr_data_rdy    in   1           downstream ready
// BEHAVIOUR
//  Reset (async assert, sync deassert): state=META_WAIT; carry=0; all val/rdy outputs 0.
//  Reset mid-packet discards the partial packet; nothing further is emitted for it.
//  Handshake: transfer when val&rdy. No val may depend on the same channel's rdy.
//  Let DB=DATA_W/8, H=20, K=DB-H.
//  META_WAIT: meta_rdy=1. On accept, carry<=hdr, then go to DATA (or CSUM, see CONFIGURATION).
//  DATA: dst_val=src_val and src_rdy=dst_rdy, combinationally (zero-latency pass-through).
//   - dst_data = {carry, src_data[DATA_W-1 -: 8K]}.
//   - On transfer, carry <= src_data[8H-1:0].
//   - On transfer with last: V = DB - padbytes.
//     - If V<=K: dst_last=1, dst_padbytes=padbytes-H, next state META_WAIT.
//     - Else: dst_last=0, next state DRAIN.
//  DRAIN: src_rdy=0, dst_val=1, dst_data={carry, 8K'b0}, dst_last=1.
//   - dst_padbytes = saved_pad + K, where saved_pad is the padbytes value registered on the last input beat.
//   - On transfer, next state META_WAIT.
//  Meta is never accepted while a packet is in flight, so at most one header is outstanding.
//  Input stalls (src_val=0) in DATA hold state and carry; output stalls hold all outputs stable.
//  Throughput: 1 beat/cycle in DATA. Latency from meta accept to the first possible output beat is 1 cycle (2 with checksum).
// CONFIGURATION
//  Macro IP_HDR_PREPEND_CSUM_EN.
//  Defined: META_WAIT -> CSUM -> DATA.
//   - CSUM lasts exactly one cycle and performs no handshakes.
//   - It computes the ones-complement sum of the 10 header 16-bit words with bytes 10-11 treated as 0, with end-around carries.
//   - It writes the complemented result into carry bytes 10-11.
//  Undefined: no CSUM state; the header is forwarded bit-exact, and the checksum field is whatever upstream supplied.
// STRUCTURE
//  Shared package packet_struct_pkg: IP_HDR_BYTES=20, IP_HDR_W=160, ip_pkt_hdr struct, IP_CSUM_BYTE_OFF=10.
//  The state enum (META_WAIT, CSUM, DATA, DRAIN) is local to the module.
//  Sub-module ip_hdr_chksum_calc: purely combinational, 160-bit header in, 16-bit checksum out; instantiated only when IP_HDR_PREPEND_CSUM_EN is defined.
// TESTING  (DATA_W=256: DB=32, K=12)
//  1. hdr=0x4500..., 1 beat with pad=28 (V=4), no stalls -> one output beat, last=1, pad=8, bytes 20..23 = payload 0..3.
//  2. Payload 3 beats, last beat pad=0 (V=32) -> 4 output beats; beat 3 = last, pad=12, first 20 bytes = payload bytes 76..95.
//  3. Payload 2 beats, last pad=20 (V=12) -> exactly 2 output beats, last pad=0, no DRAIN cycle.
//  4. Random val/rdy stalls (50%) over 200 packets of 1..1500B -> byte-exact match to a scoreboard model; outputs stable while stalled.
//  5. rst_n asserted during beat 2 of 4 -> val outputs 0 immediately; next packet emitted correctly with its own header.
//  6. CSUM_EN, hdr 4500 0073 0000 4000 4011 xxxx c0a8 0001 c0a8 00c7 -> output bytes 10-11 = 0xb861.

Source files
------------

// File: rtl/packet_struct_pkg.sv
// Shared IPv4 header definitions used by the header-prepend TX path.
// Field layout matches wire order: byte 0 of the header sits in the MSBs.
package packet_struct_pkg;

  localparam int IP_HDR_BYTES     = 20;
  localparam int IP_HDR_W         = 8 * IP_HDR_BYTES;
  localparam int IP_CSUM_BYTE_OFF = 10;

  typedef struct packed {
    logic [3:0]  version;
    logic [3:0]  ihl;
    logic [7:0]  tos;
    logic [15:0] total_len;
    logic [15:0] id;
    logic [2:0]  flags;
    logic [12:0] frag_off;
    logic [7:0]  ttl;
    logic [7:0]  protocol;
    logic [15:0] checksum;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
  } ip_pkt_hdr;

endpackage

// File: rtl/ip_hdr_chksum_calc.sv
// Combinational IPv4 header checksum: ones-complement sum of the ten 16-bit
// words with the checksum field taken as zero, folded and complemented.
module ip_hdr_chksum_calc
  import packet_struct_pkg::*;
(
  input  logic [IP_HDR_W-1:0] i_hdr,
  output logic [15:0]         o_csum
);

  localparam int NWORDS = IP_HDR_W / 16;

  ip_pkt_hdr           w_hdr;
  logic [IP_HDR_W-1:0] w_flat;
  logic [15:0]         w_words [NWORDS];
  logic [19:0]         w_sum;
  logic [16:0]         w_fold1;
  logic [15:0]         w_fold2;

  always_comb begin
    w_hdr          = i_hdr;
    w_hdr.checksum = '0;
  end

  assign w_flat = w_hdr;

  for (genvar gi = 0; gi < NWORDS; gi++) begin : g_words
    assign w_words[gi] = w_flat[IP_HDR_W-1-16*gi -: 16];
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NWORDS; i++) begin
      w_sum = w_sum + 20'(w_words[i]);
    end
  end

  // Two end-around folds are enough: ten words cannot overflow past 20 bits.
  assign w_fold1 = {1'b0, w_sum[15:0]} + 17'(w_sum[19:16]);
  assign w_fold2 = w_fold1[15:0] + 16'(w_fold1[16]);
  assign o_csum  = ~w_fold2;

endmodule

// File: rtl/ip_hdr_prepend_tx.sv
// Prepends a 20-byte IPv4 header to a payload stream, realigning payload bytes.
// Define IP_HDR_PREPEND_CSUM_EN to recompute the header checksum before output.
module ip_hdr_prepend_tx
  import packet_struct_pkg::*;
#(
  parameter int DATA_W     = 256,
  parameter int PADBYTES_W = $clog2(DATA_W / 8)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  src_hdr_meta_val,
  input  logic [IP_HDR_W-1:0]   src_hdr_meta_hdr,
  output logic                  hdr_src_meta_rdy,
  input  logic                  src_hdr_data_val,
  input  logic [DATA_W-1:0]     src_hdr_data,
  input  logic                  src_hdr_data_last,
  input  logic [PADBYTES_W-1:0] src_hdr_data_padbytes,
  output logic                  hdr_src_data_rdy,
  output logic                  hdr_dst_data_val,
  output logic [DATA_W-1:0]     hdr_dst_data,
  output logic                  hdr_dst_data_last,
  output logic [PADBYTES_W-1:0] hdr_dst_data_padbytes,
  input  logic                  dst_hdr_data_rdy
);

  localparam int DB       = DATA_W / 8;
  localparam int H        = IP_HDR_BYTES;
  localparam int K        = DB - H;
  localparam int KW       = 8 * K;
  localparam int CSUM_MSB = IP_HDR_W - 1 - 8 * IP_CSUM_BYTE_OFF;

  localparam logic [PADBYTES_W-1:0] H_PAD = PADBYTES_W'(H);
  localparam logic [PADBYTES_W-1:0] K_PAD = PADBYTES_W'(K);

  typedef enum logic [1:0] {
    META_WAIT = 2'd0,
    CSUM      = 2'd1,
    DATA      = 2'd2,
    DRAIN     = 2'd3
  } state_t;

`ifdef IP_HDR_PREPEND_CSUM_EN
  localparam state_t AFTER_META = CSUM;
`else
  localparam state_t AFTER_META = DATA;
`endif

  state_t                r_state, w_state_next;
  logic [IP_HDR_W-1:0]   r_carry, w_carry_next;
  logic [PADBYTES_W-1:0] r_saved_pad, w_saved_pad_next;
  logic                  w_src_fire;
  logic                  w_fits;

`ifdef IP_HDR_PREPEND_CSUM_EN
  logic [15:0] w_csum;

  ip_hdr_chksum_calc u_chksum (
    .i_hdr  (r_carry),
    .o_csum (w_csum)
  );
`endif

  assign w_src_fire = src_hdr_data_val && dst_hdr_data_rdy;
  // Last beat whose valid bytes all fit behind the carried header bytes.
  assign w_fits     = (src_hdr_data_padbytes >= H_PAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= META_WAIT;
      r_carry     <= '0;
      r_saved_pad <= '0;
    end else begin
      r_state     <= w_state_next;
      r_carry     <= w_carry_next;
      r_saved_pad <= w_saved_pad_next;
    end
  end

  always_comb begin
    w_state_next          = r_state;
    w_carry_next          = r_carry;
    w_saved_pad_next      = r_saved_pad;
    hdr_src_meta_rdy      = 1'b0;
    hdr_src_data_rdy      = 1'b0;
    hdr_dst_data_val      = 1'b0;
    hdr_dst_data          = {r_carry, src_hdr_data[DATA_W-1 -: KW]};
    hdr_dst_data_last     = 1'b0;
    hdr_dst_data_padbytes = '0;

    case (r_state)
      META_WAIT: begin
        // Held low while reset is asserted so no handshake appears in reset.
        hdr_src_meta_rdy = rst_n;
        if (src_hdr_meta_val) begin
          w_carry_next = src_hdr_meta_hdr;
          w_state_next = AFTER_META;
        end
      end
`ifdef IP_HDR_PREPEND_CSUM_EN
      CSUM: begin
        w_carry_next[CSUM_MSB -: 16] = w_csum;
        w_state_next                 = DATA;
      end
`endif
      DATA: begin
        hdr_dst_data_val = src_hdr_data_val;
        hdr_src_data_rdy = dst_hdr_data_rdy;
        if (src_hdr_data_last && w_fits) begin
          hdr_dst_data_last     = 1'b1;
          hdr_dst_data_padbytes = src_hdr_data_padbytes - H_PAD;
        end
        if (w_src_fire) begin
          w_carry_next = src_hdr_data[8*H-1:0];
          if (src_hdr_data_last) begin
            if (w_fits) begin
              w_state_next = META_WAIT;
            end else begin
              w_saved_pad_next = src_hdr_data_padbytes;
              w_state_next     = DRAIN;
            end
          end
        end
      end
      DRAIN: begin
        hdr_dst_data_val      = 1'b1;
        hdr_dst_data          = {r_carry, {KW{1'b0}}};
        hdr_dst_data_last     = 1'b1;
        hdr_dst_data_padbytes = r_saved_pad + K_PAD;
        if (dst_hdr_data_rdy) begin
          w_state_next = META_WAIT;
        end
      end
      default: begin
        w_state_next = META_WAIT;
      end
    endcase
  end

endmodule
